fetch_sequencer: RTL and testbench

Instruction-fetch controller for the IF stage of the five-stage LA32R pipeline. It owns the PC register and its +4 increment, drives a request/acknowledge handshake to instruction memory, and fills the IF/ID register. It redirects on taken branches or jumps, and absorbs ID-stage stalls with a one-entry skid buffer so an in-flight fetch is never lost.

---
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Purpose: IF-stage fetch controller; owns the PC, runs the imem req/ack handshake and fills IF/ID.
// Latency: data acked at edge N is on if_* after edge N; redirect target is fetched the cycle after br_taken.
// Backpressure: an ID stall on a live IF/ID parks one in-flight instruction in a skid buffer and drops imem_req.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic [31:0] skid_pc4;

    logic [31:0] tgt;
    logic [31:0] pc_next4;
    logic        out_free;

    // Word-aligned target, wrapping increment and "IF/ID can take a new entry".
    always_comb begin
        tgt      = {br_target[31:2], 2'b00};
        pc_next4 = pc + 32'd4;
        out_free = !if_valid || !stall;
    end

    // Request is dropped asynchronously by reset so memory never sees a stale request.
    assign imem_req  = rstn && (state != HOLD);
    assign imem_addr = pc;

    // Fetch state machine. A redirect while a request is outstanding only records the
    // target; pc (and so imem_addr) stays put until the memory acks, then DRAIN jumps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            redir_pc  <= 32'd0;
            skid_inst <= 32'd0;
            skid_pc   <= 32'd0;
            skid_pc4  <= 32'd0;
            if_valid  <= 1'b0;
            if_inst   <= 32'd0;
            if_pc     <= 32'd0;
            if_pc4    <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (br_taken) begin
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            pc <= tgt;
                        end else begin
                            redir_pc <= tgt;
                            state    <= DRAIN;
                        end
                    end else if (imem_ack && out_free) begin
                        if_inst  <= imem_rdata;
                        if_pc    <= pc;
                        if_pc4   <= pc_next4;
                        if_valid <= 1'b1;
                        pc       <= pc_next4;
                    end else if (imem_ack) begin
                        skid_inst <= imem_rdata;
                        skid_pc   <= pc;
                        skid_pc4  <= pc_next4;
                        pc        <= pc_next4;
                        state     <= HOLD;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        if_valid <= 1'b0;
                        pc       <= tgt;
                        state    <= FETCH;
                    end else if (!stall) begin
                        if_inst  <= skid_inst;
                        if_pc    <= skid_pc;
                        if_pc4   <= skid_pc4;
                        if_valid <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if_valid <= 1'b0;
                    if (br_taken) begin
                        redir_pc <= tgt;
                    end
                    if (imem_ack) begin
                        // A redirect landing on the ack cycle is the newest target.
                        pc    <= br_taken ? tgt : redir_pc;
                        state <= FETCH;
                    end
                end
                default: begin
                    state    <= FETCH;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    int errors;
    int checks;

    fetch_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4)
    );

    // Memory returns addr + 0x1000_0000 as the instruction word.
    assign imem_rdata = imem_addr + 32'h1000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic a);
        stall     = s;
        br_taken  = b;
        br_target = t;
        imem_ack  = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rstn      = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'd0;
        imem_ack  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h1C00_0000);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_inst",  if_inst, 32'd0);
        check("rst_pc",    if_pc, 32'd0);
        check("rst_pc4",   if_pc4, 32'd0);
        rstn = 1'b1;
        #1;
        check("run_req",   {31'd0, imem_req}, 32'd1);

        // Zero-wait streaming
        step(0, 0, 0, 1);
        check("s1_valid", {31'd0, if_valid}, 32'd1);
        check("s1_pc",    if_pc, 32'h1C00_0000);
        check("s1_inst",  if_inst, 32'h2C00_0000);
        check("s1_pc4",   if_pc4, 32'h1C00_0004);
        check("s1_addr",  imem_addr, 32'h1C00_0004);
        step(0, 0, 0, 1);
        check("s2_pc",    if_pc, 32'h1C00_0004);
        check("s2_addr",  imem_addr, 32'h1C00_0008);
        step(0, 0, 0, 1);
        check("s3_pc",    if_pc, 32'h1C00_0008);
        check("s3_addr",  imem_addr, 32'h1C00_000C);

        // Three-cycle stall with ack held high: one instruction parks in the skid buffer
        step(1, 0, 0, 1);
        check("st1_pc",   if_pc, 32'h1C00_0008);
        check("st1_req",  {31'd0, imem_req}, 32'd0);
        check("st1_addr", imem_addr, 32'h1C00_0010);
        step(1, 0, 0, 1);
        check("st2_pc",   if_pc, 32'h1C00_0008);
        check("st2_req",  {31'd0, imem_req}, 32'd0);
        step(1, 0, 0, 1);
        check("st3_pc",   if_pc, 32'h1C00_0008);
        check("st3_val",  {31'd0, if_valid}, 32'd1);
        step(0, 0, 0, 1);
        check("rel_valid", {31'd0, if_valid}, 32'd1);
        check("rel_pc",    if_pc, 32'h1C00_000C);
        check("rel_inst",  if_inst, 32'h2C00_000C);
        check("rel_req",   {31'd0, imem_req}, 32'd1);
        check("rel_addr",  imem_addr, 32'h1C00_0010);
        step(0, 0, 0, 1);
        check("rel2_pc",   if_pc, 32'h1C00_0010);
        check("rel2_addr", imem_addr, 32'h1C00_0014);

        // Delayed ack with a redirect (unaligned target) during the wait
        step(0, 0, 0, 0);
        check("w1_valid", {31'd0, if_valid}, 32'd0);
        check("w1_addr",  imem_addr, 32'h1C00_0014);
        step(0, 1, 32'h1C00_0103, 0);
        check("w2_addr",  imem_addr, 32'h1C00_0014);
        check("w2_req",   {31'd0, imem_req}, 32'd1);
        check("w2_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 1);
        check("w3_addr",  imem_addr, 32'h1C00_0100);
        check("w3_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 1);
        check("w4_valid", {31'd0, if_valid}, 32'd1);
        check("w4_pc",    if_pc, 32'h1C00_0100);
        check("w4_inst",  if_inst, 32'h2C00_0100);

        // Redirect together with stall while IF/ID is live
        step(1, 1, 32'h1C00_0180, 1);
        check("bs_valid", {31'd0, if_valid}, 32'd0);
        check("bs_addr",  imem_addr, 32'h1C00_0180);
        step(0, 0, 0, 1);
        check("bs2_pc",   if_pc, 32'h1C00_0180);
        check("bs2_valid", {31'd0, if_valid}, 32'd1);

        // Two redirects while draining: only the newest is fetched
        step(0, 1, 32'h1C00_0200, 0);
        check("d1_addr",  imem_addr, 32'h1C00_0184);
        check("d1_valid", {31'd0, if_valid}, 32'd0);
        step(0, 1, 32'h1C00_0300, 0);
        check("d2_addr",  imem_addr, 32'h1C00_0184);
        step(0, 0, 0, 1);
        check("d3_addr",  imem_addr, 32'h1C00_0300);
        check("d3_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 1);
        check("d4_pc",    if_pc, 32'h1C00_0300);
        check("d4_valid", {31'd0, if_valid}, 32'd1);

        // PC wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, 1);
        check("wr1_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        check("wr2_pc",   if_pc, 32'hFFFF_FFFC);
        check("wr2_pc4",  if_pc4, 32'h0000_0000);
        check("wr2_inst", if_inst, 32'h0FFF_FFFC);
        check("wr2_addr", imem_addr, 32'h0000_0000);
        step(0, 0, 0, 1);
        check("wr3_pc",   if_pc, 32'h0000_0000);
        check("wr3_addr", imem_addr, 32'h0000_0004);

        // Asynchronous reset in the middle of a wait
        step(0, 0, 0, 0);
        check("ar0_req",  {31'd0, imem_req}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_req",   {31'd0, imem_req}, 32'd0);
        check("ar_addr",  imem_addr, 32'h1C00_0000);
        check("ar_valid", {31'd0, if_valid}, 32'd0);
        check("ar_pc",    if_pc, 32'd0);
        check("ar_pc4",   if_pc4, 32'd0);
        check("ar_inst",  if_inst, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0, 0, 1);
        check("ar2_pc",   if_pc, 32'h1C00_0000);
        check("ar2_addr", imem_addr, 32'h1C00_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
